bin2bcd_stream: RTL and testbench
=================================

Name: bin2bcd_stream

Overview:
- Parametrised successor to the serial binary-to-decimal converter.
- Converts a WIDTH-bit binary word, unsigned or two's-complement, into DIGITS packed BCD digits using shift-and-add-3 (double dabble), one bit per clock.
- Input and output use valid/ready handshakes. Adds sign handling, a sticky overflow flag when DIGITS is too small, and a synchronous abort.
- Sits between binary datapaths and display/print logic.

Parameters:
- WIDTH, 32, binary input width (>=2)
- DIGITS, 10, number of BCD output digits (>=1)
- SIGNED, 0, 1 = input is two's complement; magnitude is converted and the sign is reported separately

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- abort  input  1  synchronous abort; discards the conversion in flight
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  binary word
- out_valid  output  1  result held valid
- out_ready  input  1  consumer accepts the result
- out_bcd  output  DIGITS*4  packed BCD; digit 0 (units) in bits [3:0]
- out_neg  output  1  result is negative (SIGNED=1 only, else 0)
- out_ovf  output  1  value did not fit in DIGITS digits; out_bcd holds value mod 10^DIGITS

Behaviour:
- Reset (rst_n low, async): state=IDLE; shift reg, BCD reg, bit counter, out_neg, out_ovf all 0.
- Outputs during reset: in_ready=0, out_valid=0, out_bcd=0. in_ready rises on the first clk edge after rst_n deasserts.
- FSM states: IDLE, CONVERT, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE, in_valid=1 (accept at edge T):
  - Load magnitude: if SIGNED and in_data[WIDTH-1], load -in_data as unsigned WIDTH bits and set neg=1; else load in_data, neg=0.
  - -2^(WIDTH-1) yields 2^(WIDTH-1), which is correct unsigned.
  - Clear BCD reg and ovf; counter=WIDTH; go to CONVERT.
- CONVERT, each edge:
  - Every digit >=5 gets +3 (all digits in parallel).
  - {BCD reg, shift reg} shifts left by 1. Shift-reg MSB enters digit 0 LSB.
  - Bit shifted out of digit DIGITS-1 ORs into ovf.
  - counter decrements.
  - The edge on which counter==1 performs the last shift and goes to DONE.
- Latency: exactly WIDTH shifts on edges T+1..T+WIDTH; out_valid=1 after edge T+WIDTH.
- DONE: out_bcd, out_neg, out_ovf stable while out_valid=1 and out_ready=0.
- DONE with out_ready=1: return to IDLE. in_ready=1 the following cycle, so minimum cycle time is WIDTH+2 clocks per word.
- out_bcd outside DONE: carries the internal BCD reg. Consumers qualify with out_valid only.
- abort=1 in any state: next state IDLE; out_valid drops; ovf/neg cleared. abort has priority over accept and over output handshake on the same edge.
- rst_n low mid-conversion: immediate return to reset values; no partial result is presented.
- Input value 0: out_bcd=0, neg=0, ovf=0 after WIDTH cycles; no early termination.
- ovf: a sticky OR over all shifts of the conversion, not just the last.

Decomposition:
- Shared package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0])
  - enum bcd_conv_state_t {IDLE, CONVERT, DONE}
  - localparam-style function for counter width, $clog2(WIDTH+1)
- Sub-module bcd_dabble_digit: one digit.
  - Inputs: digit, shift-in bit.
  - Outputs: next digit ((d>=5 ? d+3 : d) << 1 | in), shift-out bit.
  - Instantiated DIGITS times in a generate chain; the top-digit shift-out feeds ovf.

Test Plan:
- WIDTH=8, DIGITS=3, SIGNED=0: in_data=8'd255 accepted at edge T -> out_valid after edge T+8, out_bcd=12'h255, out_neg=0, out_ovf=0.
- WIDTH=8, DIGITS=2: in_data=255 -> out_bcd=8'h55, out_ovf=1. in_data=99 -> out_bcd=8'h99, out_ovf=0.
- WIDTH=8, DIGITS=3, SIGNED=1: 8'h80 -> out_bcd=12'h128, out_neg=1. 8'hFF -> 12'h001, neg=1. 8'h7F -> 12'h127, neg=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs unchanged, in_ready=0. Pulse out_ready -> in_ready=1 next cycle. Back-to-back words 0 then 1 -> 12'h000, then 12'h001.
- WIDTH=32, DIGITS=10: 32'hFFFFFFFF -> out_bcd=40'h4294967295, ovf=0, after 32 cycles.
- abort asserted 3 cycles into a conversion -> IDLE next edge, out_valid never asserts. rst_n low mid-conversion -> in_ready=0 and out_valid=0 immediately; in_ready=1 one edge after release.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types for the streaming binary-to-BCD converter.
// Digit type, FSM state encoding and bit-counter width helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } bcd_conv_state_t;

    // Counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int bcd_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit slice: add-3 correction then shift left by one.
// Purely combinational; the shift-out bit feeds the next more significant digit.
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    input  logic       i_shift,
    output bcd_digit_t o_digit,
    output logic       o_shift
);

    bcd_digit_t w_adj;

    assign w_adj   = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
    assign o_digit = {w_adj[2:0], i_shift};
    assign o_shift = w_adj[3];

endmodule

// File: rtl/bin2bcd_stream.sv
// Streaming binary to packed-BCD converter, one bit per clock (double dabble).
// Latency WIDTH clocks from accept to out_valid; result held until out_ready.
module bin2bcd_stream
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGITS*4-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  out_ovf
);

    localparam int CW = bcd_cnt_w(WIDTH);

    bcd_conv_state_t     r_state;
    bcd_conv_state_t     w_state_nxt;
    logic                r_live;
    logic [WIDTH-1:0]    r_shift;
    logic [DIGITS*4-1:0] r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_neg;
    logic                r_ovf;

    logic [DIGITS*4-1:0] w_bcd_nxt;
    logic [DIGITS:0]     w_carry;
    logic                w_is_neg;
    logic [WIDTH-1:0]    w_mag;
    logic                w_accept;

    assign w_carry[0] = r_shift[WIDTH-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_dabble_digit u_dig (
            .i_digit (r_bcd[g*4 +: 4]),
            .i_shift (w_carry[g]),
            .o_digit (w_bcd_nxt[g*4 +: 4]),
            .o_shift (w_carry[g+1])
        );
    end

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    assign w_is_neg = (SIGNED != 0) && in_data[WIDTH-1];
    assign w_mag    = w_is_neg ? ((~in_data) + WIDTH'(1)) : in_data;
    assign w_accept = (r_state == IDLE) && r_live && in_valid && !abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_live && in_valid)   w_state_nxt = CONVERT;
            CONVERT: if (r_cnt == CW'(1))      w_state_nxt = DONE;
            DONE:    if (out_ready)            w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    // r_live keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_state_nxt;
            if (abort) begin
                r_neg <= 1'b0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                r_shift <= w_mag;
                r_bcd   <= '0;
                r_cnt   <= CW'(WIDTH);
                r_neg   <= w_is_neg;
                r_ovf   <= 1'b0;
            end else if (r_state == CONVERT) begin
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                r_bcd   <= w_bcd_nxt;
                r_cnt   <= r_cnt - CW'(1);
                r_ovf   <= r_ovf | w_carry[DIGITS];
            end
        end
    end

    assign in_ready  = r_live && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_bcd   = r_bcd;
    assign out_neg   = r_neg;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Bench for bin2bcd_stream: four parameterisations, queued expectations
// checked by per-instance monitors on each output handshake.
module tb_bin2bcd_stream;

    typedef struct packed {
        logic [39:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t qd[$];

    // A: 8 bits, 3 digits, unsigned
    logic a_abort = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
    logic [7:0] a_in_data = 0;
    logic [11:0] a_out_bcd;
    logic a_out_neg, a_out_ovf;
    // B: 8 bits, 2 digits, unsigned
    logic b_abort = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
    logic [7:0] b_in_data = 0;
    logic [7:0] b_out_bcd;
    logic b_out_neg, b_out_ovf;
    // C: 8 bits, 3 digits, signed
    logic c_abort = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 1;
    logic [7:0] c_in_data = 0;
    logic [11:0] c_out_bcd;
    logic c_out_neg, c_out_ovf;
    // D: 32 bits, 10 digits, unsigned
    logic d_abort = 0, d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 1;
    logic [31:0] d_in_data = 0;
    logic [39:0] d_out_bcd;
    logic d_out_neg, d_out_ovf;

    bin2bcd_stream #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .abort(a_abort), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bcd(a_out_bcd), .out_neg(a_out_neg), .out_ovf(a_out_ovf));
    bin2bcd_stream #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_b (
        .clk(clk), .rst_n(rst_n), .abort(b_abort), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_out_bcd), .out_neg(b_out_neg), .out_ovf(b_out_ovf));
    bin2bcd_stream #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_c (
        .clk(clk), .rst_n(rst_n), .abort(c_abort), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_bcd(c_out_bcd), .out_neg(c_out_neg), .out_ovf(c_out_ovf));
    bin2bcd_stream #(.WIDTH(32), .DIGITS(10), .SIGNED(0)) u_d (
        .clk(clk), .rst_n(rst_n), .abort(d_abort), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_bcd(d_out_bcd), .out_neg(d_out_neg), .out_ovf(d_out_ovf));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [39:0] bcd, input logic neg, input logic ovf);
        exp_t e;
        e.bcd = bcd;
        e.neg = neg;
        e.ovf = ovf;
        return e;
    endfunction

    // Monitors: one pop per completed output handshake.
    exp_t ea, eb, ec, ed;
    always @(negedge clk) if (rst_n && a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_spurious", 1, 0);
        else begin ea = qa.pop_front(); chk("a_result", {a_out_bcd, a_out_neg, a_out_ovf}, {ea.bcd[11:0], ea.neg, ea.ovf}); end
    end
    always @(negedge clk) if (rst_n && b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_spurious", 1, 0);
        else begin eb = qb.pop_front(); chk("b_result", {b_out_bcd, b_out_neg, b_out_ovf}, {eb.bcd[7:0], eb.neg, eb.ovf}); end
    end
    always @(negedge clk) if (rst_n && c_out_valid && c_out_ready) begin
        if (qc.size() == 0) chk("c_spurious", 1, 0);
        else begin ec = qc.pop_front(); chk("c_result", {c_out_bcd, c_out_neg, c_out_ovf}, {ec.bcd[11:0], ec.neg, ec.ovf}); end
    end
    always @(negedge clk) if (rst_n && d_out_valid && d_out_ready) begin
        if (qd.size() == 0) chk("d_spurious", 1, 0);
        else begin ed = qd.pop_front(); chk("d_result", {d_out_bcd, d_out_neg, d_out_ovf}, {ed.bcd, ed.neg, ed.ovf}); end
    end

    // Each send starts just after a rising edge and returns #1 after the accept edge.
    task automatic send_a(input logic [7:0] d);
        int n = 0;
        a_in_data = d; a_in_valid = 1;
        while (1) begin
            @(negedge clk);
            if (a_in_ready) begin @(posedge clk); #1; a_in_valid = 0; return; end
            if (++n > 200) begin chk("a_send_timeout", 1, 0); a_in_valid = 0; return; end
        end
    endtask
    task automatic send_b(input logic [7:0] d);
        int n = 0;
        b_in_data = d; b_in_valid = 1;
        while (1) begin
            @(negedge clk);
            if (b_in_ready) begin @(posedge clk); #1; b_in_valid = 0; return; end
            if (++n > 200) begin chk("b_send_timeout", 1, 0); b_in_valid = 0; return; end
        end
    endtask
    task automatic send_c(input logic [7:0] d);
        int n = 0;
        c_in_data = d; c_in_valid = 1;
        while (1) begin
            @(negedge clk);
            if (c_in_ready) begin @(posedge clk); #1; c_in_valid = 0; return; end
            if (++n > 200) begin chk("c_send_timeout", 1, 0); c_in_valid = 0; return; end
        end
    endtask
    task automatic send_d(input logic [31:0] d);
        int n = 0;
        d_in_data = d; d_in_valid = 1;
        while (1) begin
            @(negedge clk);
            if (d_in_ready) begin @(posedge clk); #1; d_in_valid = 0; return; end
            if (++n > 200) begin chk("d_send_timeout", 1, 0); d_in_valid = 0; return; end
        end
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_bcd", a_out_bcd, 12'h000);
        @(negedge clk) rst_n = 1;
        #1 chk("rel_in_ready_pre_edge", a_in_ready, 0);
        @(posedge clk); #1;
        chk("rel_in_ready_post_edge", a_in_ready, 1);

        // Latency and backpressure on A
        a_out_ready = 0;
        qa.push_back(mk(40'h255, 0, 0));
        send_a(8'd255);
        n = 0;
        while (!a_out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("a_latency", n, 8);
        repeat (5) begin
            @(posedge clk); #1;
            chk("a_hold_bcd", a_out_bcd, 12'h255);
            chk("a_hold_valid", a_out_valid, 1);
            chk("a_hold_in_ready", a_in_ready, 0);
        end
        a_out_ready = 1;
        @(posedge clk); #1;
        chk("a_in_ready_after_pop", a_in_ready, 1);
        chk("a_valid_after_pop", a_out_valid, 0);

        // Back-to-back words
        qa.push_back(mk(40'h000, 0, 0)); send_a(8'd0);
        qa.push_back(mk(40'h001, 0, 0)); send_a(8'd1);

        // Abort three cycles into a conversion
        n = 0;
        while (!a_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        send_a(8'd77);
        repeat (3) @(posedge clk);
        #1 a_abort = 1;
        @(posedge clk); #1 a_abort = 0;
        chk("a_abort_in_ready", a_in_ready, 1);
        chk("a_abort_valid", a_out_valid, 0);
        seen = 0;
        repeat (12) begin @(posedge clk); #1; seen |= a_out_valid; end
        chk("a_abort_never_valid", seen, 0);

        // Overflow with two digits
        qb.push_back(mk(40'h55, 0, 1)); send_b(8'd255);
        qb.push_back(mk(40'h99, 0, 0)); send_b(8'd99);
        qb.push_back(mk(40'h00, 0, 1)); send_b(8'd200);

        // Signed inputs
        qc.push_back(mk(40'h128, 1, 0)); send_c(8'h80);
        qc.push_back(mk(40'h001, 1, 0)); send_c(8'hFF);
        qc.push_back(mk(40'h127, 0, 0)); send_c(8'h7F);
        qc.push_back(mk(40'h000, 0, 0)); send_c(8'h00);

        // Full 32-bit range
        qd.push_back(mk(40'h4294967295, 0, 0)); send_d(32'hFFFFFFFF);
        qd.push_back(mk(40'h1234567890, 0, 0)); send_d(32'd1234567890);
        qd.push_back(mk(40'h0000000000, 0, 0)); send_d(32'd0);

        n = 0;
        while ((qa.size() + qb.size() + qc.size() + qd.size()) != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end

        // Reset mid-conversion on D
        n = 0;
        while (!d_in_ready && n < 100) begin @(posedge clk); #1; n++; end
        send_d(32'd5);
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_d_in_ready", d_in_ready, 0);
        chk("mid_rst_d_valid", d_out_valid, 0);
        chk("mid_rst_d_bcd", d_out_bcd, 40'h0);
        @(negedge clk) rst_n = 1;
        #1 chk("mid_rel_d_in_ready_pre", d_in_ready, 0);
        @(posedge clk); #1;
        chk("mid_rel_d_in_ready_post", d_in_ready, 1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; seen |= d_out_valid; end
        chk("mid_rst_no_result", seen, 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);
        chk("qd_drained", qd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
